// File: rtl/stopwatch_counter.sv
// stopwatch_counter: divides clk to a one-second tick and keeps an MM:SS BCD time value.
// Latency: all outputs registered; en is honoured on the next rising edge.
// No backpressure: en selects clear / count / pause every cycle; pause keeps the partial second.
module stopwatch_counter #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] en,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       sec_pulse,
  output logic       wrap,
  output logic       running
);

  localparam int            DW       = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [1:0]    EN_CLEAR = 2'b00;
  localparam logic [1:0]    EN_COUNT = 2'b01;

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]    sec_ones_q, sec_ones_d;
  logic [3:0]    sec_tens_q, sec_tens_d;
  logic [3:0]    min_ones_q, min_ones_d;
  logic [3:0]    min_tens_q, min_tens_d;
  logic          sec_pulse_q, sec_pulse_d;
  logic          wrap_q, wrap_d;
  logic          running_q, running_d;
  logic          tick;

  // Next-state: prescaler, mode selection and BCD ripple carry on each one-second tick.
  always_comb begin
    div_cnt_d   = div_cnt_q;
    sec_ones_d  = sec_ones_q;
    sec_tens_d  = sec_tens_q;
    min_ones_d  = min_ones_q;
    min_tens_d  = min_tens_q;
    sec_pulse_d = 1'b0;
    wrap_d      = 1'b0;
    running_d   = (en == EN_COUNT);
    tick        = 1'b0;

    case (en)
      EN_CLEAR: begin
        div_cnt_d  = '0;
        sec_ones_d = 4'd0;
        sec_tens_d = 4'd0;
        min_ones_d = 4'd0;
        min_tens_d = 4'd0;
      end
      EN_COUNT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          tick      = 1'b1;
        end else begin
          div_cnt_d = div_cnt_q + DW'(1);
        end
      end
      default: begin
        // Pause (10 and 11): everything holds, partial second retained.
      end
    endcase

    // Ripple compare uses >= so a corrupted digit still recovers to a legal value.
    if (tick) begin
      sec_pulse_d = 1'b1;
      if (sec_ones_q >= 4'd9) begin
        sec_ones_d = 4'd0;
        if (sec_tens_q >= 4'd5) begin
          sec_tens_d = 4'd0;
          if (min_ones_q >= 4'd9) begin
            min_ones_d = 4'd0;
            if (min_tens_q >= 4'd5) begin
              min_tens_d = 4'd0;
              wrap_d     = 1'b1;
            end else begin
              min_tens_d = min_tens_q + 4'd1;
            end
          end else begin
            min_ones_d = min_ones_q + 4'd1;
          end
        end else begin
          sec_tens_d = sec_tens_q + 4'd1;
        end
      end else begin
        sec_ones_d = sec_ones_q + 4'd1;
      end
    end
  end

  // State registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q   <= '0;
      sec_ones_q  <= 4'd0;
      sec_tens_q  <= 4'd0;
      min_ones_q  <= 4'd0;
      min_tens_q  <= 4'd0;
      sec_pulse_q <= 1'b0;
      wrap_q      <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      sec_ones_q  <= sec_ones_d;
      sec_tens_q  <= sec_tens_d;
      min_ones_q  <= min_ones_d;
      min_tens_q  <= min_tens_d;
      sec_pulse_q <= sec_pulse_d;
      wrap_q      <= wrap_d;
      running_q   <= running_d;
    end
  end

  assign sec_ones  = sec_ones_q;
  assign sec_tens  = sec_tens_q;
  assign min_ones  = min_ones_q;
  assign min_tens  = min_tens_q;
  assign sec_pulse = sec_pulse_q;
  assign wrap      = wrap_q;
  assign running   = running_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter with TICK_DIV = 4: elapsed-seconds model checked every cycle,
// plus literal spot checks after each directed phase.
module tb_stopwatch_counter;

  localparam int TD = 4;

  logic       clk;
  logic       reset;
  logic [1:0] en;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       sec_pulse, wrap, running;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;

  // Model state: elapsed seconds modulo one hour plus the prescaler position.
  int m_t = 0;
  int m_div = 0;
  int m_pulse = 0;
  int m_wrap = 0;
  int m_run = 0;

  stopwatch_counter #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .en(en),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
    .sec_pulse(sec_pulse), .wrap(wrap), .running(running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the time value.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_t = 0; m_div = 0; m_pulse = 0; m_wrap = 0; m_run = 0;
    end else begin
      m_run   = (en == 2'b01) ? 1 : 0;
      m_pulse = 0;
      m_wrap  = 0;
      if (en == 2'b00) begin
        m_t = 0;
        m_div = 0;
      end else if (en == 2'b01) begin
        if (m_div == TD - 1) begin
          m_div   = 0;
          m_pulse = 1;
          m_wrap  = (m_t == 3599) ? 1 : 0;
          m_t     = (m_t + 1) % 3600;
        end else begin
          m_div = m_div + 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("sec_ones", sec_ones, (m_t % 60) % 10);
    check("sec_tens", sec_tens, (m_t % 60) / 10);
    check("min_ones", min_ones, (m_t / 60) % 10);
    check("min_tens", min_tens, (m_t / 60) / 10);
    check("sec_pulse", sec_pulse, m_pulse);
    check("wrap", wrap, m_wrap);
    check("running", running, m_run);
    check("bcd_range", (sec_ones <= 9 && min_ones <= 9 && sec_tens <= 5 && min_tens <= 5), 1);
    if (sec_pulse === 1'b1) pulse_cnt++;
  end

  // Drive en for n rising edges; returns just after a falling edge.
  task automatic run(input logic [1:0] code, input int n);
    en = code;
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check_time(input string name, input int mt, input int mo, input int st, input int so);
    check({name, "_mt"}, min_tens, mt);
    check({name, "_mo"}, min_ones, mo);
    check({name, "_st"}, sec_tens, st);
    check({name, "_so"}, sec_ones, so);
  endtask

  initial begin
    reset = 1'b1;
    en    = 2'b00;
    repeat (3) @(negedge clk);
    #1;
    check_time("in_reset", 0, 0, 0, 0);
    reset = 1'b0;

    // Basic count: 40 edges -> 10 pulses, 00:10.
    pulse_cnt = 0;
    run(2'b01, 40);
    check("basic_pulses", pulse_cnt, 10);
    check_time("basic", 0, 0, 1, 0);

    // Pause/resume with both pause codes.
    for (int p = 2; p <= 3; p++) begin
      run(2'b00, 1);
      pulse_cnt = 0;
      run(2'b01, 2);
      run(p[1:0], 50);
      check("pause_pulses", pulse_cnt, 0);
      check_time("paused", 0, 0, 0, 0);
      run(2'b01, 2);
      check("resume_so", sec_ones, 1);
      check("resume_pulses", pulse_cnt, 1);
    end

    // Clear at 03:27, then a full TICK_DIV to the first advance.
    run(2'b00, 1);
    run(2'b01, 207 * TD);
    check_time("t0327", 0, 3, 2, 7);
    run(2'b00, 1);
    check_time("cleared", 0, 0, 0, 0);
    check("cleared_running", running, 0);
    pulse_cnt = 0;
    run(2'b01, TD - 1);
    check("clr_early_pulses", pulse_cnt, 0);
    run(2'b01, 1);
    check("clr_first_pulse", pulse_cnt, 1);
    check("clr_first_so", sec_ones, 1);

    // Carries 00:59 -> 01:00 and 09:59 -> 10:00.
    run(2'b00, 1);
    run(2'b01, 59 * TD);
    check_time("t0059", 0, 0, 5, 9);
    run(2'b01, TD);
    check_time("t0100", 0, 1, 0, 0);
    run(2'b01, (599 - 60) * TD);
    check_time("t0959", 0, 9, 5, 9);
    run(2'b01, TD);
    check_time("t1000", 1, 0, 0, 0);

    // Wrap 59:59 -> 00:00.
    run(2'b01, (3599 - 600) * TD);
    check_time("t5959", 5, 9, 5, 9);
    run(2'b01, TD);
    check_time("wrapped", 0, 0, 0, 0);
    check("wrap_strobe", wrap, 1);
    check("wrap_pulse", sec_pulse, 1);
    run(2'b01, 1);
    check("wrap_one_cycle", wrap, 0);
    check("pulse_one_cycle", sec_pulse, 0);

    // Clear on a terminal-count edge: no strobe.
    run(2'b01, 2);
    pulse_cnt = 0;
    run(2'b00, 1);
    check("tc_clear_pulses", pulse_cnt, 0);
    check("tc_clear_wrap", wrap, 0);
    check_time("tc_clear", 0, 0, 0, 0);

    // Reset mid-count at 12:34 with partial second.
    run(2'b01, 754 * TD + 2);
    check_time("t1234", 1, 2, 3, 4);
    reset = 1'b1;
    #1;
    check_time("async_reset", 0, 0, 0, 0);
    check("async_reset_running", running, 0);
    run(2'b01, 2);
    reset = 1'b0;
    pulse_cnt = 0;
    run(2'b01, TD - 1);
    check("rst_early_pulses", pulse_cnt, 0);
    run(2'b01, 1);
    check("rst_first_pulse", pulse_cnt, 1);
    check("rst_first_so", sec_ones, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
